// File: rtl/rr_arbiter_fsm_if.sv
// Request/grant bundle between the contending masters and rr_arbiter_fsm.
// The master side drives the request vector; the slave side (the arbiter) returns the registered grant.
interface rr_arbiter_fsm_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               hold_expired;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  hold_expired
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output hold_expired
  );
endinterface

// File: rtl/rr_arbiter_fsm.sv
// N-channel request/grant arbiter, round-robin or fixed priority, with a registered one-hot grant.
// Optional tenure limit is enabled by defining RR_ARBITER_FSM_HOLD_LIMIT_EN.
module rr_arbiter_fsm #(
  parameter int NUM_REQ  = 4,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic              clock,
  input  logic              reset,
  rr_arbiter_fsm_if.slave   bus,
  output logic [1:0]        dbg_state
);

  // Handshake: req[i] is a level request held until served; gnt[i] is registered and stays
  // asserted while req[i] remains high; dropping req[i] ends the tenure at the next edge,
  // and every hand-off passes through one all-zero gnt cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
  } state_t;

  state_t             state_r, state_nx;
  logic [NUM_REQ-1:0] gnt_r, gnt_nx;
  logic [ID_W-1:0]    gnt_id_r, gnt_id_nx;
  logic               gnt_valid_r;
  logic [ID_W-1:0]    last_r, last_nx;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    scan_idx;
  logic               keep_grant;

`ifdef RR_ARBITER_FSM_HOLD_LIMIT_EN
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nx;
  logic              expired_r, expired_nx;
`else
  wire unused_max_hold = (MAX_HOLD > 0);
`endif

  // Winner search: RR scans upward from the channel after the last winner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (RR_MODE != 0) scan_idx = ID_W'((int'(last_r) + 1 + i) % NUM_REQ);
      else              scan_idx = ID_W'(i);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  always_comb begin
    state_nx   = IDLE;
    gnt_nx     = '0;
    gnt_id_nx  = '0;
    last_nx    = last_r;
    keep_grant = 1'b0;
`ifdef RR_ARBITER_FSM_HOLD_LIMIT_EN
    hold_cnt_nx = '0;
    expired_nx  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (win_found) begin
          state_nx  = GRANT;
          gnt_nx    = NUM_REQ'(1) << win_id;
          gnt_id_nx = win_id;
          last_nx   = win_id;
        end
      end
      GRANT: begin
        keep_grant = bus.req[gnt_id_r];
`ifdef RR_ARBITER_FSM_HOLD_LIMIT_EN
        if (keep_grant && hold_cnt_r == HOLD_W'(MAX_HOLD - 1)) begin
          keep_grant = 1'b0;
          expired_nx = 1'b1;
        end
`endif
        if (keep_grant) begin
          state_nx  = GRANT;
          gnt_nx    = NUM_REQ'(1) << gnt_id_r;
          gnt_id_nx = gnt_id_r;
`ifdef RR_ARBITER_FSM_HOLD_LIMIT_EN
          hold_cnt_nx = hold_cnt_r + HOLD_W'(1);
`endif
        end
      end
      default: begin
        // Unreachable encodings fall back to IDLE with the grant cleared.
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      gnt_r       <= '0;
      gnt_id_r    <= '0;
      gnt_valid_r <= 1'b0;
      last_r      <= ID_W'(NUM_REQ - 1);
    end else begin
      state_r     <= state_nx;
      gnt_r       <= gnt_nx;
      gnt_id_r    <= gnt_id_nx;
      gnt_valid_r <= |gnt_nx;
      last_r      <= last_nx;
    end
  end

`ifdef RR_ARBITER_FSM_HOLD_LIMIT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt_r <= '0;
      expired_r  <= 1'b0;
    end else begin
      hold_cnt_r <= hold_cnt_nx;
      expired_r  <= expired_nx;
    end
  end
  assign bus.hold_expired = expired_r;
`else
  assign bus.hold_expired = 1'b0;
`endif

  assign bus.gnt       = gnt_r;
  assign bus.gnt_id    = gnt_id_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign dbg_state     = state_r;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed bench for rr_arbiter_fsm: one round-robin and one fixed-priority instance, NUM_REQ=4, MAX_HOLD=4.
// The hold-limit sequence runs when RR_ARBITER_FSM_HOLD_LIMIT_EN is defined, the unlimited-tenure one otherwise.
module tb_rr_arbiter_fsm;

  logic       clock;
  logic       reset;
  logic [1:0] rr_state;
  logic [1:0] fp_state;
  int         n_checks;
  int         n_errors;

  rr_arbiter_fsm_if #(.NUM_REQ(4)) rr_bus ();
  rr_arbiter_fsm_if #(.NUM_REQ(4)) fp_bus ();

  rr_arbiter_fsm #(.NUM_REQ(4), .RR_MODE(1), .MAX_HOLD(4)) u_rr (
    .clock     (clock),
    .reset     (reset),
    .bus       (rr_bus.slave),
    .dbg_state (rr_state)
  );

  rr_arbiter_fsm #(.NUM_REQ(4), .RR_MODE(0), .MAX_HOLD(4)) u_fp (
    .clock     (clock),
    .reset     (reset),
    .bus       (fp_bus.slave),
    .dbg_state (fp_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_rr(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_id);
    check({tag, "_gnt"},   32'(rr_bus.gnt),       32'(exp_gnt));
    check({tag, "_id"},    32'(rr_bus.gnt_id),    32'(exp_id));
    check({tag, "_valid"}, 32'(rr_bus.gnt_valid), 32'(exp_gnt != 4'b0000));
  endtask

  task automatic check_fp(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_id);
    check({tag, "_gnt"},   32'(fp_bus.gnt),       32'(exp_gnt));
    check({tag, "_id"},    32'(fp_bus.gnt_id),    32'(exp_id));
    check({tag, "_valid"}, 32'(fp_bus.gnt_valid), 32'(exp_gnt != 4'b0000));
  endtask

  initial begin
    logic [3:0] e_gnt;
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    rr_bus.req = 4'b1111;
    fp_bus.req = 4'b0000;

    // 1: reset held two cycles with all requests pending
    for (int c = 0; c < 2; c++) begin
      step();
      check_rr("t1_rst", 4'b0000, 2'd0);
      check_fp("t1_rst_fp", 4'b0000, 2'd0);
      check("t1_rst_exp", 32'(rr_bus.hold_expired), 32'd0);
      check("t1_rst_state", 32'(rr_state), 32'd0);
    end
    reset = 1'b0;
    step();
    check_rr("t1_first", 4'b0001, 2'd0);
    check("t1_state", 32'(rr_state), 32'd1);

    // 2: round-robin rotation, each winner drops req for one cycle after 3 grant cycles
    for (int k = 0; k < 4; k++) begin
      e_gnt = 4'b0001 << k;
      for (int c = 0; c < 3; c++) begin
        check_rr("t2_hold", e_gnt, 2'(k));
        if (c < 2) step();
      end
      rr_bus.req = 4'b1111 & ~e_gnt;
      step();
      check_rr("t2_gap", 4'b0000, 2'd0);
      rr_bus.req = 4'b1111;
      step();
    end
    check_rr("t2_wrap", 4'b0001, 2'd0);

    // 3: fixed priority, lowest index wins, hand-off through one idle cycle
    fp_bus.req = 4'b1010;
    step();
    check_fp("t3_first", 4'b0010, 2'd1);
    step();
    check_fp("t3_keep", 4'b0010, 2'd1);
    fp_bus.req = 4'b1000;
    step();
    check_fp("t3_gap", 4'b0000, 2'd0);
    step();
    check_fp("t3_next", 4'b1000, 2'd3);

    // 4: reset asserted mid-tenure on channel 2
    rr_bus.req = 4'b0100;
    step();
    check_rr("t4_drop", 4'b0000, 2'd0);
    step();
    check_rr("t4_grant", 4'b0100, 2'd2);
    reset = 1'b1;
    step();
    check_rr("t4_rst", 4'b0000, 2'd0);
    check_fp("t4_rst_fp", 4'b0000, 2'd0);
    reset = 1'b0;
    step();
    check_rr("t4_regrant", 4'b0100, 2'd2);
    rr_bus.req = 4'b0000;
    step();
    check_rr("t4_idle", 4'b0000, 2'd0);

`ifdef RR_ARBITER_FSM_HOLD_LIMIT_EN
    // 5: tenure limit of 4 cycles alternates two constant requesters
    rr_bus.req = 4'b0011;
    for (int t = 0; t < 3; t++) begin
      e_gnt = (t == 1) ? 4'b0010 : 4'b0001;
      step();
      for (int c = 0; c < 4; c++) begin
        check_rr("t5_tenure", e_gnt, (t == 1) ? 2'd1 : 2'd0);
        check("t5_noexp", 32'(rr_bus.hold_expired), 32'd0);
        if (c < 3) step();
      end
      step();
      check_rr("t5_gap", 4'b0000, 2'd0);
      check("t5_exp", 32'(rr_bus.hold_expired), 32'd1);
    end
`else
    // 6: unlimited tenure, single requester held 20 cycles
    rr_bus.req = 4'b0001;
    step();
    for (int c = 0; c < 20; c++) begin
      check_rr("t6_hold", 4'b0001, 2'd0);
      check("t6_noexp", 32'(rr_bus.hold_expired), 32'd0);
      step();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_fsm.md
Name: rr_arbiter_fsm

Overview:
- Parametrised N-channel request/grant arbiter; successor to the two-channel fixed-priority grant FSM.
- Issues at most one registered one-hot grant, held while the winning request stays high.
- Selects the next winner by round-robin or fixed priority.
- Sits in front of any shared resource (bus, memory port) that several masters contend for.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- RR_MODE, 1, 1 = round-robin starting after the last granted channel; 0 = fixed priority, lowest index wins.
- MAX_HOLD, 8, maximum consecutive grant cycles per tenure; used only with the optional feature; legal range 2..256.
- ID_W, $clog2(NUM_REQ), width of gnt_id.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  request vector, level-sensitive, bit i = channel i
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when nothing is granted
- gnt_valid  output  1  registered, equals |gnt
- gnt_id  output  ID_W  registered index of the granted channel; 0 when gnt_valid=0
- hold_expired  output  1  one-cycle pulse when a tenure is force-ended by timeout; constant 0 without the optional feature

Behaviour:
- Reset (clock, synchronous, active-high) forces:
  - state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, hold_expired=0
  - rr pointer last=NUM_REQ-1, so channel 0 has first priority
  - hold counter=0
- Reset asserted mid-tenure drops the grant at that same edge; no completion cycle.
- State IDLE:
  - If req==0: stay in IDLE, gnt=0.
  - Else pick winner w:
    - RR_MODE=1: first set bit scanning last+1, last+2, ... with wrap modulo NUM_REQ.
    - RR_MODE=0: lowest set index.
  - Next edge: state=GRANT, gnt=1<<w, gnt_id=w, last=w, hold counter=0.
  - Latency: req sampled high at edge t gives gnt high after edge t (one clock).
- State GRANT:
  - If req[gnt_id]=1: keep the grant; hold counter increments, saturating.
  - If req[gnt_id]=0: next edge returns to IDLE with gnt=0.
  - Requests from other channels are ignored during GRANT.
- Grant hand-off always passes through IDLE:
  - At least one all-zero gnt cycle between consecutive tenures, including re-grant of the same channel.
  - A channel dropping req and re-raising it the next cycle loses to any other pending requester in RR mode.
- Unreachable state encodings return to IDLE with all grants cleared at the next edge.
- No combinational path from req to gnt.
- gnt is never multi-hot.
- gnt_id, gnt and gnt_valid change only together.

Optional Feature:
- Macro: RR_ARBITER_FSM_HOLD_LIMIT_EN
- Defined:
  - In GRANT, when the hold counter equals MAX_HOLD-1 and req[gnt_id] is still 1, the next edge forces IDLE, clears gnt and pulses hold_expired=1 for one cycle.
  - last already equals the expired channel, so other pending requesters win next.
  - If no other request is pending, the same channel is re-granted after the one-cycle gap.
  - A tenure therefore lasts at most MAX_HOLD cycles.
- Not defined:
  - No hold counter logic is synthesised; hold_expired is tied to 0.
  - Tenure is unlimited; MAX_HOLD is ignored.

Test Plan (NUM_REQ=4, MAX_HOLD=4):
1. reset=1 for 2 cycles with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_id=0 throughout; first edge after reset release gives gnt=4'b0001.
2. RR_MODE=1, req=4'b1111 held, each winner drops its req for 1 cycle after 3 grant cycles, then re-raises it -> grant order 0,1,2,3,0 with exactly one gnt=0 cycle between tenures.
3. RR_MODE=0, req=4'b1010 -> gnt=4'b0010; drop req[1] -> after 1 idle cycle gnt=4'b1000.
4. Grant on channel 2, assert reset for one cycle mid-tenure -> gnt=0 at that edge; after release with req=4'b0100, gnt=4'b0100 one cycle later.
5. Macro defined, req=4'b0011 held constant -> ch0 granted 4 cycles, hold_expired=1 for 1 cycle, gap, ch1 granted 4 cycles, then ch0 again.
6. Macro undefined, req=4'b0001 held 20 cycles -> gnt=4'b0001 continuously from cycle 1, hold_expired stays 0.
